// File: rtl/bcd_count_7seg_pkg.sv
// Shared constants for the BCD counter / 7-segment display block.
// Segment patterns are active-low, bit order g..a (seg[0] = a).
package bcd_count_7seg_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_count_7seg_seg7_decode.sv
// Combinational BCD nibble to 7-segment map; non-BCD codes blank the digit.
// ACTIVE_LOW=0 inverts the stored active-low patterns.
module seg7_decode
    import bcd_count_7seg_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    logic [6:0] raw;

    always_comb begin
        raw = SEG_BLANK;
        case (bcd)
            4'd0: raw = SEG_0;
            4'd1: raw = SEG_1;
            4'd2: raw = SEG_2;
            4'd3: raw = SEG_3;
            4'd4: raw = SEG_4;
            4'd5: raw = SEG_5;
            4'd6: raw = SEG_6;
            4'd7: raw = SEG_7;
            4'd8: raw = SEG_8;
            4'd9: raw = SEG_9;
            default: raw = SEG_BLANK;
        endcase
        seg = (ACTIVE_LOW != 0) ? raw : ~raw;
    end

endmodule

// File: rtl/bcd_count_7seg.sv
// Steps a DIGITS-wide BCD up/down counter on each rising edge of the divider
// toggle and time-multiplexes it onto a common-anode 7-segment display.
module bcd_count_7seg
    import bcd_count_7seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick_in,
    input  logic                      en,
    input  logic                      up,
    input  logic                      clear,
    output logic [BCD_W*DIGITS-1:0]   count_bcd,
    output logic                      carry,
    output logic [DIGITS-1:0]         an,
    output logic [6:0]                seg,
    output logic                      dp
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);
    localparam logic [DIGITS-1:0] AN_RST    = (ACTIVE_LOW != 0) ? ~AN_ONE : AN_ONE;
    localparam logic [6:0]        SEG_RST   = (ACTIVE_LOW != 0) ? SEG_0 : ~SEG_0;

    // Synchronizer and rising-edge detect; reset to 1 so a tick_in already
    // high when reset releases is not mistaken for a new edge.
    logic s1, s2, s_prev;
    logic step;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s1     <= tick_in;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign step = s2 & ~s_prev;

    // Ripple the +1/-1 through the digits; a carry out of the top digit is a wrap.
    logic [BCD_W*DIGITS-1:0] cnt_nxt;
    logic                    wrap;
    logic                    cin;
    logic [BCD_W-1:0]        d;

    always_comb begin
        cnt_nxt = count_bcd;
        cin     = 1'b1;
        d       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count_bcd[i*BCD_W +: BCD_W];
            if (cin) begin
                if (up) begin
                    if (d == 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d   = d + 4'd1;
                        cin = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d   = d - 4'd1;
                        cin = 1'b0;
                    end
                end
            end
            cnt_nxt[i*BCD_W +: BCD_W] = d;
        end
        wrap = cin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_bcd <= '0;
            carry     <= 1'b0;
        end else if (clear) begin
            count_bcd <= '0;
            carry     <= 1'b0;
        end else if (step && en) begin
            count_bcd <= cnt_nxt;
            carry     <= wrap;
        end else begin
            carry     <= 1'b0;
        end
    end

    // Display scan: hold each digit for SCAN_DIV cycles.
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [BCD_W-1:0]  cur_digit;
    logic [6:0]        seg_d;
    logic [DIGITS-1:0] an_hot;
    logic [DIGITS-1:0] an_d;

    assign cur_digit = count_bcd[idx*BCD_W +: BCD_W];

    seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
        .bcd (cur_digit),
        .seg (seg_d)
    );

    always_comb begin
        an_hot      = '0;
        an_hot[idx] = 1'b1;
        an_d        = (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_RST;
            seg <= SEG_RST;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

    assign dp = (ACTIVE_LOW != 0);

endmodule

// File: tb/tb_bcd_count_7seg.sv
// Directed bench for bcd_count_7seg with a short scan period.
module tb_bcd_count_7seg;

    logic        clk = 1'b0;
    logic        rst, tick_in, en, up, clear;
    logic [15:0] count_bcd;
    logic        carry;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int errs   = 0;
    int checks = 0;

    bcd_count_7seg #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .en        (en),
        .up        (up),
        .clear     (clear),
        .count_bcd (count_bcd),
        .carry     (carry),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pulse(input int hi);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        tick_in = 1'b1;
        repeat (hi) @(negedge clk);
        tick_in = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) pulse(1);
        repeat (4) @(negedge clk);
    endtask

    // One step; sample count/carry right after the update edge and one cycle later.
    task automatic tick_obs(output logic [15:0] c, output logic cy1, output logic cy2);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        tick_in = 1'b1;
        repeat (3) @(negedge clk);
        c   = count_bcd;
        cy1 = carry;
        @(negedge clk);
        cy2 = carry;
        repeat (6) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] v, input string tag);
        int n = 0;
        while (an !== v && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (an !== v) chk(tag, an, v);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    logic [15:0] c;
    logic        cy1, cy2;
    logic [3:0]  exp_an  [4];
    logic [6:0]  exp_seg [4];

    initial begin
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

        rst = 1'b1; tick_in = 1'b1; en = 1'b1; up = 1'b1; clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst count", count_bcd, 16'h0000);
        chk("rst carry", carry, 1'b0);
        chk("rst an", an, 4'b1110);
        chk("rst seg", seg, 7'b1000000);
        chk("rst dp", dp, 1'b1);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("release no step", count_bcd, 16'h0000);

        // Latency: update lands on the 3rd edge counting the sampling edge.
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk); chk("lat edge1", count_bcd, 16'h0000);
        @(negedge clk); chk("lat edge2", count_bcd, 16'h0000);
        @(negedge clk); chk("lat edge3", count_bcd, 16'h0001);
        chk("lat carry", carry, 1'b0);
        repeat (47) @(negedge clk);
        chk("long high once", count_bcd, 16'h0001);
        repeat (11) pulse(50);
        repeat (4) @(negedge clk);
        chk("up 12", count_bcd, 16'h0012);

        do_clear();
        chk("clear", count_bcd, 16'h0000);
        up = 1'b0;
        tick_obs(c, cy1, cy2);
        chk("down wrap", c, 16'h9999);
        chk("down carry", cy1, 1'b1);
        chk("down carry end", cy2, 1'b0);
        up = 1'b1;
        tick_obs(c, cy1, cy2);
        chk("up wrap", c, 16'h0000);
        chk("up carry", cy1, 1'b1);
        chk("up carry end", cy2, 1'b0);

        // clear beats a coincident step
        pulses(457);
        chk("count 457", count_bcd, 16'h0457);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear vs step", count_bcd, 16'h0000);
        chk("clear carry", carry, 1'b0);
        repeat (10) @(negedge clk);
        chk("step dropped", count_bcd, 16'h0000);
        tick_in = 1'b0;

        pulses(1);
        chk("count 1", count_bcd, 16'h0001);
        en = 1'b0;
        repeat (5) begin
            tick_obs(c, cy1, cy2);
            chk("en0 hold", c, 16'h0001);
            chk("en0 carry", cy1, 1'b0);
        end
        en = 1'b1;

        // Scan of 1234
        do_clear();
        pulses(1234);
        chk("count 1234", count_bcd, 16'h1234);
        wait_an(4'b0111, "scan sync3");
        wait_an(4'b1110, "scan sync0");
        for (int k = 0; k < 16; k++) begin
            chk("scan an", an, exp_an[k/4]);
            chk("scan seg", seg, exp_seg[k/4]);
            @(negedge clk);
        end

        // Reset in the middle of a scan
        do_clear();
        pulses(789);
        chk("count 789", count_bcd, 16'h0789);
        wait_an(4'b1011, "mid sync2");
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst count", count_bcd, 16'h0000);
        chk("mid rst carry", carry, 1'b0);
        chk("mid rst an", an, 4'b1110);
        chk("mid rst seg", seg, 7'b1000000);
        chk("mid rst dp", dp, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("restart an0", an, 4'b1110);
            chk("restart seg0", seg, 7'b1000000);
        end
        @(negedge clk);
        chk("restart an1", an, 4'b1101);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "timeout");
    end

endmodule
